// File: rtl/cpc_mem_pkg.sv
// Shared types and ROM-bank helper for the CPC SDRAM arbiter.
// Bank IDs are address bits [22:14] (16 KB granularity).
package cpc_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_BOOT,
        SRC_CPU,
        SRC_DMA
    } arb_src_t;

    localparam logic [8:0] ROM_BANK_LOW_MAX = 9'h0FF;
    localparam logic [8:0] ROM_BANK_LOWER   = 9'h100;
    localparam logic [8:0] ROM_BANK_AMSDOS  = 9'h107;

    function automatic logic is_rom_bank(input logic [8:0] bank);
        return (bank <= ROM_BANK_LOW_MAX) || (bank == ROM_BANK_LOWER) ||
               (bank == ROM_BANK_AMSDOS);
    endfunction

endpackage

// File: rtl/cpc_arb_pick.sv
// Combinational requester selector: boot first, then dma when the cpu has
// hogged FAIR_MAX slots in a row, then cpu, then dma.
module cpc_arb_pick
    import cpc_mem_pkg::*;
#(
    parameter int FAIR_MAX = 4
) (
    input  logic       boot_req,
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic [2:0] fair_cnt,
    output arb_src_t   src,
    output logic       valid
);

    localparam logic [2:0] FAIR_LIM = 3'(FAIR_MAX);

    // NOTE: every output gets a default before the priority chain, so no latch is inferred.
    always_comb begin
        src   = SRC_DMA;
        valid = boot_req | cpu_req | dma_req;
        if (boot_req) begin
            src = SRC_BOOT;
        end else if (dma_req && (fair_cnt == FAIR_LIM)) begin
            src = SRC_DMA;
        end else if (cpu_req) begin
            src = SRC_CPU;
        end
    end

endmodule

// File: rtl/cpc_sdram_arbiter.sv
// One-access-per-clkref arbiter in front of zsdram for boot, cpu and dma.
// Define ARB_ROM_WP_EN to suppress cpu writes that land in ROM banks.
module cpc_sdram_arbiter
    import cpc_mem_pkg::*;
#(
    parameter int RD_LAT   = 8,
    parameter int FAIR_MAX = 4
) (
    input  logic        clk_sys,
    input  logic        RESET_n,
    input  logic        clkref,
    input  logic        boot_req,
    input  logic [22:0] boot_a,
    input  logic [7:0]  boot_d,
    output logic        boot_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [22:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [22:0] dma_a,
    input  logic [7:0]  dma_d,
    output logic [7:0]  dma_q,
    output logic        dma_ack,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [7:0]  mem_din,
    input  logic [7:0]  mem_dout,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 2);
    localparam logic [2:0] FAIR_LIM  = 3'(FAIR_MAX);

    arb_state_t  state, state_nx;
    arb_src_t    pick_src, cur_src;
    logic        pick_valid;
    logic        grant;
    logic [3:0]  wait_cnt;
    logic [2:0]  fair_cnt;
    logic        sel_we;
    logic        sel_wr_en;
    logic [22:0] sel_a;
    logic [7:0]  sel_d;

    cpc_arb_pick #(
        .FAIR_MAX (FAIR_MAX)
    ) u_pick (
        .boot_req (boot_req),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .fair_cnt (fair_cnt),
        .src      (pick_src),
        .valid    (pick_valid)
    );

    always_comb begin
        sel_we = 1'b1;
        sel_a  = boot_a;
        sel_d  = boot_d;
        case (pick_src)
            SRC_CPU: begin
                sel_we = cpu_we;
                sel_a  = cpu_a;
                sel_d  = cpu_d;
            end
            SRC_DMA: begin
                sel_we = dma_we;
                sel_a  = dma_a;
                sel_d  = dma_d;
            end
            default: ;
        endcase
    end

`ifdef ARB_ROM_WP_EN
    // A blocked cpu write still owns its slot; only the strobe is withheld.
    assign sel_wr_en = !((pick_src == SRC_CPU) && is_rom_bank(cpu_a[22:14]));
`else
    assign sel_wr_en = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (clkref && pick_valid) begin
                    state_nx = ARB_ISSUE;
                    grant    = 1'b1;
                end
            end
            ARB_ISSUE: state_nx = ARB_WAIT;
            ARB_WAIT:  if (wait_cnt == 4'd0) state_nx = ARB_DONE;
            ARB_DONE:  state_nx = ARB_IDLE;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) state <= ARB_IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            cur_src  <= SRC_BOOT;
            wait_cnt <= '0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_din  <= '0;
            boot_ack <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            cpu_q    <= '0;
            dma_q    <= '0;
        end else begin
            boot_ack <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant) begin
                        cur_src <= pick_src;
                        mem_oe  <= ~sel_we;
                        mem_we  <= sel_we & sel_wr_en;
                        mem_a   <= sel_a;
                        mem_din <= sel_d;
                    end
                end
                ARB_ISSUE: wait_cnt <= WAIT_LOAD;
                ARB_WAIT: begin
                    // Leaving WAIT is exactly RD_LAT edges after the issue edge.
                    if (wait_cnt == 4'd0) begin
                        case (cur_src)
                            SRC_BOOT: boot_ack <= 1'b1;
                            SRC_CPU: begin
                                cpu_ack <= 1'b1;
                                if (mem_oe) cpu_q <= mem_dout;
                            end
                            SRC_DMA: begin
                                dma_ack <= 1'b1;
                                if (mem_oe) dma_q <= mem_dout;
                            end
                            default: ;
                        endcase
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ARB_DONE: begin
                    mem_oe <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            fair_cnt <= '0;
        end else if (!dma_req) begin
            fair_cnt <= '0;
        end else if (grant && (pick_src == SRC_DMA)) begin
            fair_cnt <= '0;
        end else if (grant && (pick_src == SRC_CPU) && (fair_cnt != FAIR_LIM)) begin
            fair_cnt <= fair_cnt + 3'd1;
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_cpc_sdram_arbiter.sv
// Self-checking bench for cpc_sdram_arbiter: vector table plus scoreboard
// queues of expected bus issues and acks, with hand-written corner sequences.
module tb_cpc_sdram_arbiter;
    import cpc_mem_pkg::*;

    localparam int RD_LAT = 8;
`ifdef ARB_ROM_WP_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk_sys, RESET_n, clkref;
    logic        boot_req, boot_ack;
    logic [22:0] boot_a;
    logic [7:0]  boot_d;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [22:0] cpu_a;
    logic [7:0]  cpu_d, cpu_q;
    logic        dma_req, dma_we, dma_ack;
    logic [22:0] dma_a;
    logic [7:0]  dma_d, dma_q;
    logic        mem_oe, mem_we, busy;
    logic [22:0] mem_a;
    logic [7:0]  mem_din, mem_dout;

    cpc_sdram_arbiter #(.RD_LAT(RD_LAT), .FAIR_MAX(4)) dut (
        .clk_sys (clk_sys), .RESET_n (RESET_n), .clkref (clkref),
        .boot_req(boot_req), .boot_a(boot_a), .boot_d(boot_d), .boot_ack(boot_ack),
        .cpu_req (cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q   (cpu_q), .cpu_ack(cpu_ack),
        .dma_req (dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_d(dma_d),
        .dma_q   (dma_q), .dma_ack(dma_ack),
        .mem_oe  (mem_oe), .mem_we(mem_we), .mem_a(mem_a), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    typedef struct {
        arb_src_t    src;
        logic        we;
        logic [22:0] a;
        logic [7:0]  d;
        logic        exp_we;
        logic [7:0]  exp_q;
    } vec_t;

    typedef struct {
        logic        oe;
        logic        we;
        logic [22:0] a;
        logic [7:0]  d;
    } iss_t;

    typedef struct {
        arb_src_t   src;
        logic       rd;
        logic [7:0] q;
    } ack_t;

    iss_t iss_q[$];
    ack_t ack_q[$];
    logic [7:0] mem_arr [logic [22:0]];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  ack_total = 0;
    int  lat = 0;
    bit  auto_drop = 1'b1;
    time last_ref_time = 0;
    time last_ack_time = 0;
    time prev_ack_time = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        int ph = 0;
        clkref = 1'b0;
        forever begin
            @(negedge clk_sys);
            ph = (ph + 1) % 16;
            clkref = (ph == 0);
            if (ph == 0) last_ref_time = $time;
        end
    end

    // Bus monitor, memory model and ack scoreboard.
    initial begin
        logic       busy_d = 1'b0;
        logic [32:0] held = '0;
        int         n_ack;
        iss_t       ie;
        ack_t       ae;
        arb_src_t   got;
        mem_dout = 8'hEE;
        forever begin
            @(negedge clk_sys);
            if (busy && !busy_d) begin
                lat = 0;
                check("issue_after_clkref", $time - last_ref_time, 10);
                check("issue_queued", iss_q.size() != 0, 1);
                if (iss_q.size() != 0) begin
                    ie = iss_q.pop_front();
                    check("issue_bus", {mem_oe, mem_we, mem_a, mem_din}, {ie.oe, ie.we, ie.a, ie.d});
                end
                held = {mem_oe, mem_we, mem_a, mem_din};
            end else if (busy) begin
                lat++;
            end
            if (!busy && busy_d) check("idle_strobes", {mem_oe, mem_we}, 2'b00);
            if (busy && mem_we) mem_arr[mem_a] = mem_din;
            mem_dout = (busy && mem_oe && lat == RD_LAT - 1 && mem_arr.exists(mem_a))
                       ? mem_arr[mem_a] : 8'hEE;
            n_ack = int'(boot_ack) + int'(cpu_ack) + int'(dma_ack);
            if (n_ack != 0) begin
                ack_total++;
                prev_ack_time = last_ack_time;
                last_ack_time = $time;
                check("one_ack", n_ack, 1);
                check("ack_latency", lat, RD_LAT);
                check("bus_held", {mem_oe, mem_we, mem_a, mem_din}, held);
                got = boot_ack ? SRC_BOOT : (cpu_ack ? SRC_CPU : SRC_DMA);
                check("ack_queued", ack_q.size() != 0, 1);
                if (ack_q.size() != 0) begin
                    ae = ack_q.pop_front();
                    check("ack_src", got, ae.src);
                    if (ae.rd) check("read_q", (got == SRC_DMA) ? dma_q : cpu_q, ae.q);
                end
                if (auto_drop) begin
                    if (boot_ack) boot_req = 1'b0;
                    if (cpu_ack)  cpu_req  = 1'b0;
                    if (dma_ack)  dma_req  = 1'b0;
                end
            end
            busy_d = busy;
        end
    end

    task automatic start_access(input arb_src_t src, input logic we, input logic [22:0] a,
                                input logic [7:0] d, input logic exp_we, input logic [7:0] exp_q);
        iss_q.push_back('{oe: ~we, we: exp_we, a: a, d: d});
        ack_q.push_back('{src: src, rd: ~we, q: exp_q});
        case (src)
            SRC_BOOT: begin boot_a = a; boot_d = d; boot_req = 1'b1; end
            SRC_CPU:  begin cpu_we = we; cpu_a = a; cpu_d = d; cpu_req = 1'b1; end
            default:  begin dma_we = we; dma_a = a; dma_d = d; dma_req = 1'b1; end
        endcase
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk_sys);
            #1;
            n++;
        end while ((ack_q.size() != 0 || busy) && n < budget);
        check("done_in_budget", ack_q.size(), 0);
        ack_q.delete();
        iss_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[14];
    logic [7:0] last_cpu_q;

    initial begin
        int n;
        int snap;
        vecs[0]  = '{SRC_CPU,  1'b0, 23'h000123, 8'h00, 1'b0, 8'h5A};
        vecs[1]  = '{SRC_CPU,  1'b1, 23'h400000, 8'h77, !WP,  8'h00};
        vecs[2]  = '{SRC_CPU,  1'b0, 23'h400000, 8'h00, 1'b0, WP ? 8'h99 : 8'h77};
        vecs[3]  = '{SRC_CPU,  1'b1, 23'h41C000, 8'h22, !WP,  8'h00};
        vecs[4]  = '{SRC_CPU,  1'b1, 23'h404000, 8'h33, 1'b1, 8'h00};
        vecs[5]  = '{SRC_CPU,  1'b0, 23'h404000, 8'h00, 1'b0, 8'h33};
        vecs[6]  = '{SRC_DMA,  1'b1, 23'h010000, 8'hC3, 1'b1, 8'h00};
        vecs[7]  = '{SRC_DMA,  1'b0, 23'h010000, 8'h00, 1'b0, 8'hC3};
        vecs[8]  = '{SRC_BOOT, 1'b1, 23'h003FFF, 8'h5E, 1'b1, 8'h00};
        vecs[9]  = '{SRC_CPU,  1'b0, 23'h003FFF, 8'h00, 1'b0, 8'h5E};
        vecs[10] = '{SRC_CPU,  1'b1, 23'h3FC000, 8'h44, !WP,  8'h00};
        vecs[11] = '{SRC_CPU,  1'b0, 23'h3FC000, 8'h00, 1'b0, WP ? 8'h10 : 8'h44};
        vecs[12] = '{SRC_CPU,  1'b1, 23'h420000, 8'h55, 1'b1, 8'h00};
        vecs[13] = '{SRC_CPU,  1'b0, 23'h420000, 8'h00, 1'b0, 8'h55};

        mem_arr[23'h000123] = 8'h5A;
        mem_arr[23'h400000] = 8'h99;
        mem_arr[23'h3FC000] = 8'h10;
        mem_arr[23'h404100] = 8'hA1;
        mem_arr[23'h010100] = 8'hB2;

        RESET_n = 1'b0;
        boot_req = 1'b0; boot_a = '0; boot_d = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_a = '0; dma_d = '0;
        repeat (3) @(negedge clk_sys);
        check("reset_outputs",
              {boot_ack, cpu_ack, dma_ack, cpu_q, dma_q, mem_oe, mem_we, mem_a, mem_din, busy}, '0);
        #2 RESET_n = 1'b1;

        // Single accesses from the table: reads, ROM-bank writes, dma and boot.
        last_cpu_q = 8'h00;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk_sys);
            #1;
            start_access(vecs[i].src, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp_we, vecs[i].exp_q);
            wait_done(60);
            if (vecs[i].src == SRC_CPU && !vecs[i].we) last_cpu_q = vecs[i].exp_q;
            else check("cpu_q_held", cpu_q, last_cpu_q);
            check("busy_between", busy, 1'b0);
        end

        // Boot and cpu on the same clkref: boot this slot, cpu the next.
        @(negedge clk_sys);
        #1;
        start_access(SRC_BOOT, 1'b1, 23'h000500, 8'hA5, 1'b1, 8'h00);
        start_access(SRC_CPU,  1'b0, 23'h000123, 8'h00, 1'b0, 8'h5A);
        wait_done(80);
        check("slot_gap", last_ack_time - prev_ack_time, 160);

        // cpu and dma both held: four cpu grants, one forced dma, repeated.
        auto_drop = 1'b0;
        @(negedge clk_sys);
        #1;
        snap = ack_total;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) start_access(SRC_DMA, 1'b0, 23'h010100, 8'h00, 1'b0, 8'hB2);
            else            start_access(SRC_CPU, 1'b0, 23'h404100, 8'h00, 1'b0, 8'hA1);
        end
        n = 0;
        while (ack_total < snap + 10 && n < 250) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        auto_drop = 1'b1;
        check("fair_acks", ack_total - snap, 10);
        wait_done(40);

        // Reset in WAIT: strobes drop at once, no ack, retry on a later slot.
        @(negedge clk_sys);
        #1;
        start_access(SRC_CPU, 1'b0, 23'h000123, 8'h00, 1'b0, 8'h5A);
        n = 0;
        while (!(busy && lat >= 3) && n < 60) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check("reached_wait", busy && lat >= 3, 1'b1);
        #1 RESET_n = 1'b0;
        #1;
        check("reset_mid_access", {mem_oe, mem_we, busy, boot_ack, cpu_ack, dma_ack}, '0);
        ack_q.delete();
        snap = ack_total;
        repeat (3) @(negedge clk_sys);
        #2 RESET_n = 1'b1;
        start_access(SRC_CPU, 1'b0, 23'h000123, 8'h00, 1'b0, 8'h5A);
        wait_done(60);
        check("single_ack_after_reset", ack_total - snap, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
